// File: rtl/decode_sequencer.sv
// Decode-flow sequencer: VGA display -> UART load -> M2 (IDCT) -> M1 (upsample/CSC) -> VGA,
// owning the shared SRAM port. Define DECODE_PERF_COUNT_EN to add per-milestone dwell counters.
module decode_sequencer #(
    parameter int unsigned        TIMER_W         = 26,
    parameter int unsigned        WD_W            = 28,
    parameter logic [TIMER_W-1:0] UART_TIMEOUT    = TIMER_W'(49999999),
    parameter logic [WD_W-1:0]    WATCHDOG_CYCLES = WD_W'(200000000)
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        UART_RX_I,
    input  logic [17:0] uart_sram_address,
    input  logic [15:0] uart_sram_write_data,
    input  logic        uart_sram_we_n,
    input  logic [17:0] m1_sram_address,
    input  logic [15:0] m1_sram_write_data,
    input  logic        m1_sram_we_n,
    input  logic        m1_stop,
    input  logic [17:0] m2_sram_address,
    input  logic [15:0] m2_sram_write_data,
    input  logic        m2_sram_we_n,
    input  logic        m2_stop,
    input  logic [17:0] vga_sram_address,
    output logic [17:0] sram_address,
    output logic [15:0] sram_write_data,
    output logic        sram_we_n,
    output logic        uart_rx_initialize,
    output logic        uart_rx_enable,
    output logic        m1_enable,
    output logic        m2_enable,
    output logic        vga_enable,
    output logic [2:0]  state_o,
    output logic        watchdog_error
`ifdef DECODE_PERF_COUNT_EN
    ,
    output logic [31:0] m2_cycles,
    output logic [31:0] m1_cycles
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_UART_RX = 3'd1;
    localparam logic [2:0] S_M2      = 3'd2;
    localparam logic [2:0] S_M1      = 3'd3;

    logic [2:0]         r_state,    w_state_nxt;
    logic               r_vga_en,   w_vga_en_nxt;
    logic               r_rx_init,  w_rx_init_nxt;
    logic               r_rx_en,    w_rx_en_nxt;
    logic               r_m1_en,    w_m1_en_nxt;
    logic               r_m2_en,    w_m2_en_nxt;
    logic               r_wd_err,   w_wd_err_nxt;
    logic [TIMER_W-1:0] r_timer,    w_timer_nxt;
    logic [WD_W-1:0]    r_wd,       w_wd_nxt;
    logic [WD_W-1:0]    w_wd_inc;
    logic               w_wd_expired;

    assign w_wd_inc     = (&r_wd) ? r_wd : r_wd + WD_W'(1);
    assign w_wd_expired = (r_wd >= WATCHDOG_CYCLES);

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_vga_en  <= 1'b1;
            r_rx_init <= 1'b0;
            r_rx_en   <= 1'b0;
            r_m1_en   <= 1'b0;
            r_m2_en   <= 1'b0;
            r_wd_err  <= 1'b0;
            r_timer   <= '0;
            r_wd      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vga_en  <= w_vga_en_nxt;
            r_rx_init <= w_rx_init_nxt;
            r_rx_en   <= w_rx_en_nxt;
            r_m1_en   <= w_m1_en_nxt;
            r_m2_en   <= w_m2_en_nxt;
            r_wd_err  <= w_wd_err_nxt;
            r_timer   <= w_timer_nxt;
            r_wd      <= w_wd_nxt;
        end
    end

    // Next state; start/initialise strobes default low so they only ever last one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_vga_en_nxt  = r_vga_en;
        w_rx_init_nxt = 1'b0;
        w_rx_en_nxt   = 1'b0;
        w_m1_en_nxt   = 1'b0;
        w_m2_en_nxt   = 1'b0;
        w_wd_err_nxt  = r_wd_err;
        w_timer_nxt   = r_timer;
        w_wd_nxt      = r_wd;
        case (r_state)
            S_IDLE: begin
                w_vga_en_nxt = 1'b1;
                if (!UART_RX_I) begin
                    w_rx_init_nxt = 1'b1;
                    w_vga_en_nxt  = 1'b0;
                    w_timer_nxt   = '0;
                    w_state_nxt   = S_UART_RX;
                end
            end
            S_UART_RX: begin
                w_rx_en_nxt = r_rx_init;
                // A write restarts the quiet-time count even on the cycle it would expire.
                if (!uart_sram_we_n) begin
                    w_timer_nxt = '0;
                end else if (r_timer == UART_TIMEOUT) begin
                    w_timer_nxt = '0;
                    w_m2_en_nxt = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_M2;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            S_M2: begin
                w_wd_nxt = w_wd_inc;
                if (!r_m2_en && m2_stop) begin
                    w_m1_en_nxt = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_M1;
                end else if (w_wd_expired) begin
                    w_wd_err_nxt = 1'b1;
                    w_vga_en_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_M1: begin
                w_wd_nxt = w_wd_inc;
                if (!r_m1_en && m1_stop) begin
                    w_vga_en_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (w_wd_expired) begin
                    w_wd_err_nxt = 1'b1;
                    w_vga_en_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_vga_en_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // SRAM port owner follows the registered mode; VGA reads whenever no unit owns it.
    always_comb begin
        sram_address    = vga_sram_address;
        sram_write_data = '0;
        sram_we_n       = 1'b1;
        case (r_state)
            S_UART_RX: begin
                sram_address    = uart_sram_address;
                sram_write_data = uart_sram_write_data;
                sram_we_n       = uart_sram_we_n;
            end
            S_M2: begin
                sram_address    = m2_sram_address;
                sram_write_data = m2_sram_write_data;
                sram_we_n       = m2_sram_we_n;
            end
            S_M1: begin
                sram_address    = m1_sram_address;
                sram_write_data = m1_sram_write_data;
                sram_we_n       = m1_sram_we_n;
            end
            default: begin
                sram_address    = vga_sram_address;
                sram_write_data = '0;
                sram_we_n       = 1'b1;
            end
        endcase
    end

    assign uart_rx_initialize = r_rx_init;
    assign uart_rx_enable     = r_rx_en;
    assign m1_enable          = r_m1_en;
    assign m2_enable          = r_m2_en;
    assign vga_enable         = r_vga_en;
    assign state_o            = r_state;
    assign watchdog_error     = r_wd_err;

`ifdef DECODE_PERF_COUNT_EN
    logic [31:0] r_m2_cycles;
    logic [31:0] r_m1_cycles;

    // Dwell counters clear on the entering edge and hold their last value once the state is left.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_m2_cycles <= '0;
            r_m1_cycles <= '0;
        end else begin
            if (r_state != S_M2 && w_state_nxt == S_M2) begin
                r_m2_cycles <= '0;
            end else if (r_state == S_M2 && r_m2_cycles != 32'hFFFF_FFFF) begin
                r_m2_cycles <= r_m2_cycles + 32'd1;
            end
            if (r_state != S_M1 && w_state_nxt == S_M1) begin
                r_m1_cycles <= '0;
            end else if (r_state == S_M1 && r_m1_cycles != 32'hFFFF_FFFF) begin
                r_m1_cycles <= r_m1_cycles + 32'd1;
            end
        end
    end

    assign m2_cycles = r_m2_cycles;
    assign m1_cycles = r_m1_cycles;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: randomised load/milestone runs predicted from event timing
// (quiet-time expiry, stop offsets, watchdog limit) rather than from the FSM itself.
module tb_decode_sequencer;

    localparam int TO_I = 100;
    localparam int WD_I = 1000;

    logic        CLOCK_50_I;
    logic        resetn;
    logic        UART_RX_I;
    logic [17:0] uart_sram_address;
    logic [15:0] uart_sram_write_data;
    logic        uart_sram_we_n;
    logic [17:0] m1_sram_address;
    logic [15:0] m1_sram_write_data;
    logic        m1_sram_we_n;
    logic        m1_stop;
    logic [17:0] m2_sram_address;
    logic [15:0] m2_sram_write_data;
    logic        m2_sram_we_n;
    logic        m2_stop;
    logic [17:0] vga_sram_address;
    logic [17:0] sram_address;
    logic [15:0] sram_write_data;
    logic        sram_we_n;
    logic        uart_rx_initialize;
    logic        uart_rx_enable;
    logic        m1_enable;
    logic        m2_enable;
    logic        vga_enable;
    logic [2:0]  state_o;
    logic        watchdog_error;
`ifdef DECODE_PERF_COUNT_EN
    logic [31:0] m2_cycles;
    logic [31:0] m1_cycles;
`endif

    int   n_cmp;
    int   n_err;
    int   cyc;
    int   exp_m2c;
    int   exp_m1c;
    logic exp_werr;

    decode_sequencer #(
        .UART_TIMEOUT    (26'd100),
        .WATCHDOG_CYCLES (28'd1000)
    ) dut (
        .CLOCK_50_I           (CLOCK_50_I),
        .resetn               (resetn),
        .UART_RX_I            (UART_RX_I),
        .uart_sram_address    (uart_sram_address),
        .uart_sram_write_data (uart_sram_write_data),
        .uart_sram_we_n       (uart_sram_we_n),
        .m1_sram_address      (m1_sram_address),
        .m1_sram_write_data   (m1_sram_write_data),
        .m1_sram_we_n         (m1_sram_we_n),
        .m1_stop              (m1_stop),
        .m2_sram_address      (m2_sram_address),
        .m2_sram_write_data   (m2_sram_write_data),
        .m2_sram_we_n         (m2_sram_we_n),
        .m2_stop              (m2_stop),
        .vga_sram_address     (vga_sram_address),
        .sram_address         (sram_address),
        .sram_write_data      (sram_write_data),
        .sram_we_n            (sram_we_n),
        .uart_rx_initialize   (uart_rx_initialize),
        .uart_rx_enable       (uart_rx_enable),
        .m1_enable            (m1_enable),
        .m2_enable            (m2_enable),
        .vga_enable           (vga_enable),
        .state_o              (state_o),
        .watchdog_error       (watchdog_error)
`ifdef DECODE_PERF_COUNT_EN
        ,
        .m2_cycles            (m2_cycles),
        .m1_cycles            (m1_cycles)
`endif
    );

    initial CLOCK_50_I = 1'b0;
    always #5 CLOCK_50_I = ~CLOCK_50_I;

    task automatic step();
        @(posedge CLOCK_50_I);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [2:0] st, input logic vga,
                            input logic ini, input logic rxe, input logic m2e, input logic m1e);
        chk({tag, ".state"},    32'(state_o),            32'(st));
        chk({tag, ".vga_en"},   32'(vga_enable),         32'(vga));
        chk({tag, ".rx_init"},  32'(uart_rx_initialize), 32'(ini));
        chk({tag, ".rx_en"},    32'(uart_rx_enable),     32'(rxe));
        chk({tag, ".m2_en"},    32'(m2_enable),          32'(m2e));
        chk({tag, ".m1_en"},    32'(m1_enable),          32'(m1e));
        chk({tag, ".wd_err"},   32'(watchdog_error),     32'(exp_werr));
    endtask

    // src: 0 VGA, 1 UART, 2 M2, 3 M1
    task automatic chk_mux(input string tag, input int src);
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ew;
        ea = vga_sram_address;
        ed = 16'h0000;
        ew = 1'b1;
        if (src == 1) begin
            ea = uart_sram_address; ed = uart_sram_write_data; ew = uart_sram_we_n;
        end else if (src == 2) begin
            ea = m2_sram_address; ed = m2_sram_write_data; ew = m2_sram_we_n;
        end else if (src == 3) begin
            ea = m1_sram_address; ed = m1_sram_write_data; ew = m1_sram_we_n;
        end
        chk({tag, ".sram_addr"}, 32'(sram_address),    32'(ea));
        chk({tag, ".sram_data"}, 32'(sram_write_data), 32'(ed));
        chk({tag, ".sram_we_n"}, 32'(sram_we_n),       32'(ew));
    endtask

    task automatic chk_perf(input string tag);
`ifdef DECODE_PERF_COUNT_EN
        chk({tag, ".m2_cycles"}, m2_cycles, 32'(exp_m2c));
        chk({tag, ".m1_cycles"}, m1_cycles, 32'(exp_m1c));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic rand_ms_bus();
        m1_sram_address    = 18'($urandom);
        m1_sram_write_data = 16'($urandom);
        m1_sram_we_n       = 1'($urandom);
        m2_sram_address    = 18'($urandom);
        m2_sram_write_data = 16'($urandom);
        m2_sram_we_n       = 1'($urandom);
        vga_sram_address   = 18'($urandom);
    endtask

    task automatic rand_uart_bus(input bit wr);
        uart_sram_address    = 18'($urandom);
        uart_sram_write_data = 16'($urandom);
        uart_sram_we_n       = !wr;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            rand_ms_bus();
            rand_uart_bus(1'b0);
            UART_RX_I = 1'b1;
            m1_stop   = 1'($urandom);
            m2_stop   = 1'($urandom);
            #1;
            chk_ctrl("idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_mux("idle", 0);
            step();
        end
    endtask

    task automatic enter_uart();
        rand_ms_bus();
        rand_uart_bus(1'b0);
        m1_stop   = 1'b0;
        m2_stop   = 1'b0;
        UART_RX_I = 1'b0;
        step();
        UART_RX_I = 1'b1;
        chk_ctrl("uart_entry", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_mux("uart_entry", 1);
    endtask

    // Load ends TO+1 cycles after the last timer restart (entry or write), a write winning a tie.
    task automatic run_uart(input int nw);
        int k_u;
        int g;
        k_u = 0;
        for (int w = 0; w < nw; w++) begin
            g = ($urandom_range(0, 3) == 0) ? TO_I + 1 : int'($urandom_range(1, TO_I));
            for (int k = 1; k <= g; k++) begin
                rand_uart_bus(k == g);
                rand_ms_bus();
                m1_stop = 1'($urandom);
                m2_stop = 1'($urandom);
                step();
                k_u++;
                chk_ctrl("uart_load", 3'd1, 1'b0, 1'b0, k_u == 1, 1'b0, 1'b0);
                chk_mux("uart_load", 1);
            end
        end
        for (int k = 1; k <= TO_I + 1; k++) begin
            rand_uart_bus(1'b0);
            rand_ms_bus();
            step();
            k_u++;
            if (k <= TO_I) begin
                chk_ctrl("uart_quiet", 3'd1, 1'b0, 1'b0, k_u == 1, 1'b0, 1'b0);
                chk_mux("uart_quiet", 1);
            end else begin
                chk_ctrl("uart_timeout", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                chk_mux("uart_timeout", 2);
            end
        end
    endtask

    // Stop counts from the second cycle in the state; with none by cycle WD_I the watchdog fires.
    task automatic run_ms(input bit is_m2, input int d, input int rst_at, output int oc);
        logic [2:0] st;
        string      nm;
        bit         fire;
        bit         abort;
        st = is_m2 ? 3'd2 : 3'd3;
        nm = is_m2 ? "m2" : "m1";
        oc = 1;
        for (int idx = 0; idx <= WD_I; idx++) begin
            rand_ms_bus();
            rand_uart_bus(1'b0);
            if (is_m2) begin
                m2_stop = (idx == d) || (idx == 0 && $urandom_range(0, 1) == 1);
                m1_stop = 1'($urandom);
            end else begin
                m1_stop = (idx == d) || (idx == 0 && $urandom_range(0, 1) == 1);
                m2_stop = 1'($urandom);
            end
            if (idx == rst_at) begin
                m1_sram_we_n   = 1'b0;
                m2_sram_we_n   = 1'b0;
                uart_sram_we_n = 1'b0;
                resetn         = 1'b0;
                #1;
                exp_werr = 1'b0;
                exp_m2c  = 0;
                exp_m1c  = 0;
                chk_ctrl("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk_mux("async_reset", 0);
                chk_perf("async_reset");
                step();
                resetn = 1'b1;
                oc = 2;
                return;
            end
            #1;
            chk_ctrl({nm, "_run"}, st, 1'b0, 1'b0, 1'b0, is_m2 && idx == 0, !is_m2 && idx == 0);
            chk_mux({nm, "_run"}, is_m2 ? 2 : 3);
            fire  = (idx == d);
            abort = !fire && (idx == WD_I);
            step();
            if (fire || abort) begin
                if (is_m2) exp_m2c = idx + 1;
                else       exp_m1c = idx + 1;
                if (abort) exp_werr = 1'b1;
                if (fire && is_m2) begin
                    chk_ctrl("m2_done", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    chk_mux("m2_done", 3);
                end else begin
                    chk_ctrl(abort ? {nm, "_abort"} : {nm, "_done"}, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    chk_mux(abort ? {nm, "_abort"} : {nm, "_done"}, 0);
                end
                oc = abort ? 1 : 0;
                return;
            end
        end
    endtask

    task automatic do_load(input string tag, input int nw, input int d2, input int d1, input int rst1);
        int oc;
        enter_uart();
        run_uart(nw);
        run_ms(1'b1, d2, -1, oc);
        if (oc == 0) run_ms(1'b0, d1, rst1, oc);
        chk_perf(tag);
        run_idle(3);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        cyc      = 0;
        exp_m2c  = 0;
        exp_m1c  = 0;
        exp_werr = 1'b0;
        resetn   = 1'b1;
        UART_RX_I            = 1'b1;
        uart_sram_address    = 18'h0;
        uart_sram_write_data = 16'h0;
        uart_sram_we_n       = 1'b1;
        m1_sram_address      = 18'h0;
        m1_sram_write_data   = 16'h0;
        m1_sram_we_n         = 1'b0;
        m1_stop              = 1'b0;
        m2_sram_address      = 18'h0;
        m2_sram_write_data   = 16'h0;
        m2_sram_we_n         = 1'b0;
        m2_stop              = 1'b0;
        vga_sram_address     = 18'h23E00;
        #2;
        resetn = 1'b0;
        #1;
        chk_ctrl("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.sram_addr_23E00", 32'(sram_address), 32'h23E00);
        chk("reset.sram_we_n", 32'(sram_we_n), 32'd1);
        chk_perf("reset");
        step();
        step();
        resetn = 1'b1;
        step();
        run_idle(4);

        do_load("basic", 2, 5, 3, -1);
        do_load("m2_watchdog", 1, -1, 0, -1);
        do_load("sticky_error", 1, 7, 4, -1);
        do_load("stop_at_limit", 0, WD_I, 2, -1);
        do_load("m1_watchdog", 0, 3, -1, -1);
        do_load("reset_mid_m1", 1, 4, 50, 10);
        do_load("after_reset", 1, 6, 9, -1);
        for (int i = 0; i < 6; i++) begin
            do_load("random", int'($urandom_range(0, 4)), int'($urandom_range(1, 40)),
                    int'($urandom_range(1, 40)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
